// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter sharing one slave port.
// Round-robin grant is held for a whole CYC; a stall watchdog terminates hung cycles with ERR.
module wb_arbiter2 #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (core)
  input  logic        m0_CYC,
  input  logic        m0_STB,
  input  logic        m0_WE,
  input  logic [31:0] m0_ADR,
  input  logic [31:0] m0_DAT_O,
  input  logic [2:0]  m0_CTI_O,
  output logic        m0_ACK,
  output logic        m0_ERR,
  output logic        m0_RTY,
  output logic [31:0] m0_DAT_I,
  // master 1 (loader / debug)
  input  logic        m1_CYC,
  input  logic        m1_STB,
  input  logic        m1_WE,
  input  logic [31:0] m1_ADR,
  input  logic [31:0] m1_DAT_O,
  input  logic [2:0]  m1_CTI_O,
  output logic        m1_ACK,
  output logic        m1_ERR,
  output logic        m1_RTY,
  output logic [31:0] m1_DAT_I,
  // shared slave
  output logic        s_CYC,
  output logic        s_STB,
  output logic        s_WE,
  output logic [31:0] s_ADR,
  output logic [31:0] s_DAT_O,
  output logic [2:0]  s_CTI_O,
  input  logic        s_ACK,
  input  logic        s_ERR,
  input  logic        s_RTY,
  input  logic [31:0] s_DAT_I,
  // status
  output logic [1:0]  grant,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    TOERR = 2'd3
  } state_t;

  localparam bit              WDOG_EN = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nxt;
  logic            last;
  logic            last_nxt;
  logic            owner;
  logic            owner_nxt;
  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_nxt;

  logic            own;
  logic            own_cyc;
  logic            own_stb;
  logic            s_term;

  // owner is meaningful in OWN0/OWN1/TOERR; it remembers who to ERR and where to return
  assign own     = (state == OWN0) || (state == OWN1);
  assign own_cyc = owner ? m1_CYC : m0_CYC;
  assign own_stb = owner ? m1_STB : m0_STB;
  assign s_term  = s_ACK | s_ERR | s_RTY;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    owner_nxt = owner;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        // on a tie the master that did not finish last wins
        if (m0_CYC && (!m1_CYC || last)) begin
          state_nxt = OWN0;
          owner_nxt = 1'b0;
        end else if (m1_CYC) begin
          state_nxt = OWN1;
          owner_nxt = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end else if (WDOG_EN && own_stb && !s_term) begin
          if (cnt == TO_LAST) begin
            state_nxt = TOERR;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      TOERR: begin
        if (own_cyc) begin
          state_nxt = owner ? OWN1 : OWN0;
        end else begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // slave side depends only on registered state and master inputs, never on s_* inputs
  always_comb begin
    s_CYC   = 1'b0;
    s_STB   = 1'b0;
    s_WE    = 1'b0;
    s_ADR   = '0;
    s_DAT_O = '0;
    s_CTI_O = '0;
    if (own) begin
      if (owner) begin
        s_CYC   = m1_CYC;
        s_STB   = m1_STB;
        s_WE    = m1_WE;
        s_ADR   = m1_ADR;
        s_DAT_O = m1_DAT_O;
        s_CTI_O = m1_CTI_O;
      end else begin
        s_CYC   = m0_CYC;
        s_STB   = m0_STB;
        s_WE    = m0_WE;
        s_ADR   = m0_ADR;
        s_DAT_O = m0_DAT_O;
        s_CTI_O = m0_CTI_O;
      end
    end
  end

  // responses reach only the owner; a reset cycle suppresses them so an abort stays silent
  assign m0_ACK = ~rst & (state == OWN0) & s_ACK;
  assign m0_RTY = ~rst & (state == OWN0) & s_RTY;
  assign m0_ERR = ~rst & (((state == OWN0) & s_ERR) | ((state == TOERR) & ~owner));
  assign m1_ACK = ~rst & (state == OWN1) & s_ACK;
  assign m1_RTY = ~rst & (state == OWN1) & s_RTY;
  assign m1_ERR = ~rst & (((state == OWN1) & s_ERR) | ((state == TOERR) & owner));

  assign m0_DAT_I = s_DAT_I;
  assign m1_DAT_I = s_DAT_I;

  assign grant   = {(state == OWN1) | ((state == TOERR) & owner),
                    (state == OWN0) | ((state == TOERR) & ~owner)};
  assign timeout = (state == TOERR);

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2: stimulus queues expected bus events, a negedge monitor checks them.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_CYC = 0, m0_STB = 0, m0_WE = 0;
  logic [31:0] m0_ADR = '0, m0_DAT_O = '0;
  logic [2:0]  m0_CTI_O = '0;
  logic        m1_CYC = 0, m1_STB = 0, m1_WE = 0;
  logic [31:0] m1_ADR = '0, m1_DAT_O = '0;
  logic [2:0]  m1_CTI_O = '0;
  logic        s_ACK = 0, s_ERR = 0, s_RTY = 0;
  logic [31:0] s_DAT_I = '0;
  logic        m0_ACK, m0_ERR, m0_RTY, m1_ACK, m1_ERR, m1_RTY;
  logic [31:0] m0_DAT_I, m1_DAT_I;
  logic        s_CYC, s_STB, s_WE;
  logic [31:0] s_ADR, s_DAT_O;
  logic [2:0]  s_CTI_O;
  logic [1:0]  grant;
  logic        timeout;

  wb_arbiter2 #(.TIMEOUT(4), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_CYC(m0_CYC), .m0_STB(m0_STB), .m0_WE(m0_WE), .m0_ADR(m0_ADR),
    .m0_DAT_O(m0_DAT_O), .m0_CTI_O(m0_CTI_O), .m0_ACK(m0_ACK), .m0_ERR(m0_ERR),
    .m0_RTY(m0_RTY), .m0_DAT_I(m0_DAT_I),
    .m1_CYC(m1_CYC), .m1_STB(m1_STB), .m1_WE(m1_WE), .m1_ADR(m1_ADR),
    .m1_DAT_O(m1_DAT_O), .m1_CTI_O(m1_CTI_O), .m1_ACK(m1_ACK), .m1_ERR(m1_ERR),
    .m1_RTY(m1_RTY), .m1_DAT_I(m1_DAT_I),
    .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE), .s_ADR(s_ADR), .s_DAT_O(s_DAT_O),
    .s_CTI_O(s_CTI_O), .s_ACK(s_ACK), .s_ERR(s_ERR), .s_RTY(s_RTY), .s_DAT_I(s_DAT_I),
    .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  grant;
    logic [2:0]  r0;   // m0 {ACK,ERR,RTY}
    logic [2:0]  r1;   // m1 {ACK,ERR,RTY}
    logic        to;
    logic        sc;
    logic        ss;
    logic [31:0] adr;
    logic [31:0] dat;
  } ev_t;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cyc = '0;
  logic        mon_en = 1'b0;
  logic [1:0]  prev_grant = 2'b00;
  ev_t         got_ev;
  ev_t         exp_ev;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input logic [31:0] at, input logic [1:0] g,
                               input logic [2:0] r0, input logic [2:0] r1, input logic to,
                               input logic sc, input logic ss, input logic [31:0] adr,
                               input logic [31:0] dat);
    ev_t e;
    e.cyc = at; e.grant = g; e.r0 = r0; e.r1 = r1; e.to = to;
    e.sc = sc; e.ss = ss; e.adr = adr; e.dat = dat;
    exp_q.push_back(e);
  endfunction

  // monitor: any grant change, response or timeout pulse is an event to be matched
  always @(negedge clk) begin
    if (mon_en && ((grant !== prev_grant) || m0_ACK || m0_ERR || m0_RTY ||
                   m1_ACK || m1_ERR || m1_RTY || timeout)) begin
      got_ev.cyc   = cyc;
      got_ev.grant = grant;
      got_ev.r0    = {m0_ACK, m0_ERR, m0_RTY};
      got_ev.r1    = {m1_ACK, m1_ERR, m1_RTY};
      got_ev.to    = timeout;
      got_ev.sc    = s_CYC;
      got_ev.ss    = s_STB;
      got_ev.adr   = s_ADR;
      got_ev.dat   = m0_ACK ? m0_DAT_I : (m1_ACK ? m1_DAT_I : 32'h0);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got cyc=%0d grant=%b r0=%b r1=%b to=%b cyc/stb=%b%b adr=%h dat=%h, required no event",
                 got_ev.cyc, got_ev.grant, got_ev.r0, got_ev.r1, got_ev.to, got_ev.sc,
                 got_ev.ss, got_ev.adr, got_ev.dat);
      end else begin
        exp_ev = exp_q.pop_front();
        if (got_ev !== exp_ev) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d grant=%b r0=%b r1=%b to=%b cyc/stb=%b%b adr=%h dat=%h, required cyc=%0d grant=%b r0=%b r1=%b to=%b cyc/stb=%b%b adr=%h dat=%h",
                   got_ev.cyc, got_ev.grant, got_ev.r0, got_ev.r1, got_ev.to, got_ev.sc,
                   got_ev.ss, got_ev.adr, got_ev.dat,
                   exp_ev.cyc, exp_ev.grant, exp_ev.r0, exp_ev.r1, exp_ev.to, exp_ev.sc,
                   exp_ev.ss, exp_ev.adr, exp_ev.dat);
        end
      end
    end
    if (mon_en) prev_grant = grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    n_checks++;
    if ({grant, timeout, s_CYC, s_STB, s_WE, s_ADR, s_DAT_O, s_CTI_O,
         m0_ACK, m0_ERR, m0_RTY, m1_ACK, m1_ERR, m1_RTY} !== '0) begin
      n_fail++;
      $display("FAIL %s: grant=%b timeout=%b s_CYC=%b s_STB=%b s_ADR=%h m0 ack/err/rty=%b%b%b m1 ack/err/rty=%b%b%b, required all zero",
               name, grant, timeout, s_CYC, s_STB, s_ADR, m0_ACK, m0_ERR, m0_RTY,
               m1_ACK, m1_ERR, m1_RTY);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_CYC = 0; m0_STB = 0; m0_WE = 0; m0_ADR = '0; m0_CTI_O = '0;
    m1_CYC = 0; m1_STB = 0; m1_WE = 0; m1_ADR = '0; m1_CTI_O = '0;
    s_ACK = 0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset_state");
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: bench did not finish, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_reset("initial_reset");
    mon_en = 1'b1;

    // single m0 read
    m0_CYC = 1; m0_STB = 1; m0_ADR = 32'h10;
    push(cyc + 1, 2'b01, 3'b000, 3'b000, 0, 1, 1, 32'h10, 32'h0);
    tick();
    tick();
    s_ACK = 1; s_DAT_I = 32'hDEADBEEF;
    push(cyc, 2'b01, 3'b100, 3'b000, 0, 1, 1, 32'h10, 32'hDEADBEEF);
    tick();
    s_ACK = 0; m0_CYC = 0; m0_STB = 0;
    push(cyc + 1, 2'b00, 3'b000, 3'b000, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();

    // simultaneous requests, then alternation
    do_reset();
    m0_CYC = 1; m0_STB = 1; m0_ADR = 32'h100;
    m1_CYC = 1; m1_STB = 1; m1_ADR = 32'h200;
    push(cyc + 1, 2'b01, 3'b000, 3'b000, 0, 1, 1, 32'h100, 32'h0);
    tick();
    tick();
    s_ACK = 1; s_DAT_I = 32'h11111111;
    push(cyc, 2'b01, 3'b100, 3'b000, 0, 1, 1, 32'h100, 32'h11111111);
    tick();
    s_ACK = 0; m0_CYC = 0; m0_STB = 0;
    push(cyc + 1, 2'b00, 3'b000, 3'b000, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();
    s_ACK = 1; s_DAT_I = 32'h22222222; m0_CYC = 1; m0_STB = 1;
    push(cyc, 2'b10, 3'b000, 3'b100, 0, 1, 1, 32'h200, 32'h22222222);
    tick();
    s_ACK = 0; m1_CYC = 0; m1_STB = 0;
    push(cyc + 1, 2'b00, 3'b000, 3'b000, 0, 0, 0, 32'h0, 32'h0);
    tick();
    m1_CYC = 1; m1_STB = 1;
    push(cyc + 1, 2'b01, 3'b000, 3'b000, 0, 1, 1, 32'h100, 32'h0);
    tick();
    tick();
    s_ACK = 1; s_DAT_I = 32'h33333333;
    push(cyc, 2'b01, 3'b100, 3'b000, 0, 1, 1, 32'h100, 32'h33333333);
    tick();
    s_ACK = 0; m0_CYC = 0; m0_STB = 0; m1_CYC = 0; m1_STB = 0;
    push(cyc + 1, 2'b00, 3'b000, 3'b000, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();

    // m1 incrementing burst while m0 waits
    do_reset();
    m1_CYC = 1; m1_STB = 1; m1_WE = 1; m1_ADR = 32'h300; m1_CTI_O = 3'b010;
    push(cyc + 1, 2'b10, 3'b000, 3'b000, 0, 1, 1, 32'h300, 32'h0);
    tick();
    m0_CYC = 1; m0_STB = 1; m0_ADR = 32'h400;
    for (int k = 0; k < 4; k++) begin
      tick();
      m1_ADR = 32'h300 + 32'(4 * k);
      m1_CTI_O = (k == 3) ? 3'b111 : 3'b010;
      s_ACK = 1; s_DAT_I = 32'hA0 + 32'(k);
      push(cyc, 2'b10, 3'b000, 3'b100, 0, 1, 1, 32'h300 + 32'(4 * k), 32'hA0 + 32'(k));
    end
    tick();
    s_ACK = 0; m1_CYC = 0; m1_STB = 0;
    push(cyc + 1, 2'b00, 3'b000, 3'b000, 0, 0, 0, 32'h0, 32'h0);
    push(cyc + 2, 2'b01, 3'b000, 3'b000, 0, 1, 1, 32'h400, 32'h0);
    tick();
    tick();
    tick();
    s_ACK = 1; s_DAT_I = 32'hBB;
    push(cyc, 2'b01, 3'b100, 3'b000, 0, 1, 1, 32'h400, 32'hBB);
    tick();
    s_ACK = 0; m0_CYC = 0; m0_STB = 0;
    push(cyc + 1, 2'b00, 3'b000, 3'b000, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();

    // watchdog fires, late ACK dropped, then an ACK on the last allowed stall cycle
    do_reset();
    m0_CYC = 1; m0_STB = 1; m0_ADR = 32'h500;
    push(cyc + 1, 2'b01, 3'b000, 3'b000, 0, 1, 1, 32'h500, 32'h0);
    push(cyc + 5, 2'b01, 3'b010, 3'b000, 1, 0, 0, 32'h0, 32'h0);
    repeat (5) tick();
    s_ACK = 1; s_DAT_I = 32'hBAD0BAD0;
    tick();
    s_ACK = 0;
    repeat (3) tick();
    s_ACK = 1; s_DAT_I = 32'h5A5A5A5A;
    push(cyc, 2'b01, 3'b100, 3'b000, 0, 1, 1, 32'h500, 32'h5A5A5A5A);
    tick();
    s_ACK = 0; m0_CYC = 0; m0_STB = 0;
    push(cyc + 1, 2'b00, 3'b000, 3'b000, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();

    // reset in the middle of an m1 burst
    do_reset();
    m1_CYC = 1; m1_STB = 1; m1_ADR = 32'h600; m1_CTI_O = 3'b010;
    push(cyc + 1, 2'b10, 3'b000, 3'b000, 0, 1, 1, 32'h600, 32'h0);
    tick();
    tick();
    s_ACK = 1; s_DAT_I = 32'hC0;
    push(cyc, 2'b10, 3'b000, 3'b100, 0, 1, 1, 32'h600, 32'hC0);
    tick();
    s_ACK = 0; rst = 1;
    m0_CYC = 1; m0_STB = 1; m0_ADR = 32'h700;
    push(cyc + 1, 2'b00, 3'b000, 3'b000, 0, 0, 0, 32'h0, 32'h0);
    tick();
    check_reset("reset_mid_burst");
    rst = 0;
    push(cyc + 1, 2'b01, 3'b000, 3'b000, 0, 1, 1, 32'h700, 32'h0);
    tick();
    tick();
    s_ACK = 1; s_DAT_I = 32'hC1;
    push(cyc, 2'b01, 3'b100, 3'b000, 0, 1, 1, 32'h700, 32'hC1);
    tick();
    s_ACK = 0; m0_CYC = 0; m0_STB = 0; m1_CYC = 0; m1_STB = 0;
    push(cyc + 1, 2'b00, 3'b000, 3'b000, 0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();
    tick();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
